// File: rtl/link_pkg.sv
// Shared definitions for the off-chip link transmit/receive blocks:
// scheduler FSM states, default sizing constants and the credit-width helper.
package link_pkg;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        DONE
    } link_state_t;

    localparam int unsigned LINK_DEF_CREDITS    = 8;
    localparam int unsigned LINK_DEF_DATA_WIDTH = 64;

    // Counter must hold the full value CREDITS, not just CREDITS-1.
    function automatic int unsigned link_credit_width(input int unsigned credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/link_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found when searching from ptr upward, wrapping modulo NUM_REQ.
module link_rr_arb #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic          w_found;
    logic [IW-1:0] w_idx;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = IW'((32'(ptr) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/link_tx_sched.sv
// Credit-based round-robin transmit scheduler with flush sequence for the link.
// Optional macro LINK_TX_SCHED_TOKEN_SYNC_EN adds a 2-flop synchronizer on token_in.
module link_tx_sched
    import link_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = LINK_DEF_DATA_WIDTH,
    parameter int unsigned CREDITS    = LINK_DEF_CREDITS,
    parameter int unsigned CW         = link_credit_width(CREDITS),
    parameter int unsigned IW         = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          link_valid,
    output logic [DATA_WIDTH-1:0]         link_data,
    output logic [IW-1:0]                 link_owner,
    input  logic                          link_ready,
    input  logic                          token_in,
    input  logic                          flush_req,
    output logic                          flush_done,
    output logic [CW-1:0]                 credits,
    output logic                          err_overflow
);

    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    link_state_t           r_state, w_state_nxt;
    logic [IW-1:0]         r_ptr, w_sel;
    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_go, w_accept, w_ret, w_tok, r_tok_q;
    logic                  r_link_valid, r_err;
    logic [DATA_WIDTH-1:0] r_link_data;
    logic [IW-1:0]         r_link_owner;
    logic [CW-1:0]         r_credits;

`ifdef LINK_TX_SCHED_TOKEN_SYNC_EN
    logic [1:0] r_tok_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_tok_sync <= '0;
        else      r_tok_sync <= {r_tok_sync[0], token_in};
    end
    assign w_tok = r_tok_sync[1];
`else
    assign w_tok = token_in;
`endif

    link_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant)
    );

    // flush_req gates issue directly so nothing is accepted in the cycle it is first seen.
    assign w_go      = (r_state == RUN) && !flush_req && (r_credits != '0)
                       && (!r_link_valid || link_ready);
    assign req_ready = (rst && w_go) ? w_grant : '0;
    assign w_accept  = |(req_valid & req_ready);
    assign w_ret     = w_tok ^ r_tok_q;

    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) w_sel = IW'(i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        flush_done  = 1'b0;
        case (r_state)
            RUN:     if (flush_req) w_state_nxt = FLUSH;
            FLUSH:   if (r_credits == FULL && !r_link_valid) w_state_nxt = DONE;
            DONE: begin
                flush_done = 1'b1;
                if (!flush_req) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= RUN;
            r_ptr        <= '0;
            r_tok_q      <= 1'b0;
            r_link_valid <= 1'b0;
            r_link_data  <= '0;
            r_link_owner <= '0;
            r_credits    <= FULL;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tok_q <= w_tok;
            if (w_accept) begin
                r_link_valid <= 1'b1;
                r_link_data  <= req_data[w_sel*DATA_WIDTH +: DATA_WIDTH];
                r_link_owner <= w_sel;
                r_ptr        <= (w_sel == IW'(NUM_REQ-1)) ? '0 : w_sel + 1'b1;
            end else if (link_ready) begin
                r_link_valid <= 1'b0;
            end
            // Simultaneous accept and return cancel out, including at full count.
            if (w_accept && !w_ret) begin
                r_credits <= r_credits - 1'b1;
            end else if (!w_accept && w_ret) begin
                if (r_credits == FULL) r_err <= 1'b1;
                else                   r_credits <= r_credits + 1'b1;
            end
        end
    end

    assign link_valid   = r_link_valid;
    assign link_data    = r_link_data;
    assign link_owner   = r_link_owner;
    assign credits      = r_credits;
    assign err_overflow = r_err;

endmodule

// File: tb/tb_link_tx_sched.sv
// Scoreboard bench for link_tx_sched (default build, 2 requesters, 8 credits).
module tb_link_tx_sched;

    logic         clk, rst;
    logic [1:0]   req_valid, req_ready;
    logic [127:0] req_data;
    logic         link_valid, link_ready, token_in, flush_req, flush_done, err_overflow;
    logic [63:0]  link_data;
    logic [0:0]   link_owner;
    logic [3:0]   credits;

    link_tx_sched #(.NUM_REQ(2), .DATA_WIDTH(64), .CREDITS(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .link_valid(link_valid), .link_data(link_data),
        .link_owner(link_owner), .link_ready(link_ready), .token_in(token_in),
        .flush_req(flush_req), .flush_done(flush_done), .credits(credits),
        .err_overflow(err_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [0:0]  owner;
        logic [63:0] data;
    } exp_t;

    exp_t       sbq[$];
    int         npass = 0;
    int         ntot  = 0;
    int         m_cred, m_state;
    logic [0:0] m_ptr;
    logic       m_lv, m_tok, m_err;
    logic [1:0] obs_rdy;

    function automatic logic [1:0] rr_model(input logic [1:0] v, input logic [0:0] p);
        logic [0:0] q;
        q = ~p;
        if (v[p]) return 2'b01 << p;
        if (v[q]) return 2'b01 << q;
        return 2'b00;
    endfunction

    task automatic do_reset();
        rst        = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        link_ready = 1'b1;
        token_in   = 1'b0;
        flush_req  = 1'b0;
        m_cred = 8; m_state = 0; m_ptr = '0; m_lv = 1'b0; m_tok = 1'b0; m_err = 1'b0;
        sbq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One cycle from a negedge: drive, check combinational accept and the taken word,
    // advance the model, then check registered state at the following negedge.
    task automatic step(input logic [1:0] v, input logic lr, input logic tog, input logic fl);
        logic [1:0] exp_rdy;
        logic       go, acc, ret;
        logic [0:0] idx;
        int         ns;
        exp_t       e;
        req_valid  = v;
        link_ready = lr;
        flush_req  = fl;
        if (tog) token_in = ~token_in;
        req_data = {$urandom, $urandom, $urandom, $urandom};
        #1;
        go      = (m_state == 0) && !fl && (m_cred != 0) && (!m_lv || lr);
        exp_rdy = go ? rr_model(v, m_ptr) : 2'b00;
        obs_rdy = req_ready;
        ntot++;
        if (req_ready !== exp_rdy) $display("FAIL req_ready: got %b want %b", req_ready, exp_rdy);
        else npass++;
        ntot++;
        if (link_valid !== m_lv) $display("FAIL link_valid: got %b want %b", link_valid, m_lv);
        else npass++;
        if (m_lv && lr) begin
            ntot++;
            if (sbq.size() == 0) begin
                $display("FAIL scoreboard_empty: got word with no expectation");
            end else begin
                e = sbq.pop_front();
                if (link_owner !== e.owner || link_data !== e.data)
                    $display("FAIL link_word: got %0d/%h want %0d/%h",
                             link_owner, link_data, e.owner, e.data);
                else npass++;
            end
        end
        ret = token_in ^ m_tok;
        acc = (exp_rdy != 2'b00);
        idx = exp_rdy[1] ? 1'b1 : 1'b0;
        ns  = m_state;
        if (m_state == 0 && fl) ns = 1;
        else if (m_state == 1 && m_cred == 8 && !m_lv) ns = 2;
        else if (m_state == 2 && !fl) ns = 0;
        if (acc) begin
            e.owner = idx;
            e.data  = idx ? req_data[127:64] : req_data[63:0];
            sbq.push_back(e);
            m_lv  = 1'b1;
            m_ptr = ~idx;
        end else if (lr) begin
            m_lv = 1'b0;
        end
        if (acc && !ret) m_cred--;
        else if (!acc && ret) begin
            if (m_cred == 8) m_err = 1'b1;
            else m_cred++;
        end
        m_tok   = token_in;
        m_state = ns;
        @(posedge clk);
        @(negedge clk);
        ntot++;
        if (credits !== 4'(m_cred) || err_overflow !== m_err || flush_done !== (m_state == 2))
            $display("FAIL state: got cred=%0d err=%b done=%b want cred=%0d err=%b done=%b",
                     credits, err_overflow, flush_done, m_cred, m_err, m_state == 2);
        else npass++;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        req_valid  = 2'b11;
        link_ready = 1'b1;
        token_in   = 1'b0;
        flush_req  = 1'b0;
        req_data   = '1;
        @(negedge clk);
        #1;
        ntot++;
        if (req_ready !== 2'b00 || link_valid !== 1'b0 || link_data !== 64'd0 || link_owner !== 1'b0)
            $display("FAIL reset_link: got rdy=%b v=%b d=%h o=%0d want 00/0/0/0",
                     req_ready, link_valid, link_data, link_owner);
        else npass++;
        ntot++;
        if (credits !== 4'd8 || flush_done !== 1'b0 || err_overflow !== 1'b0)
            $display("FAIL reset_state: got cred=%0d done=%b err=%b want 8/0/0",
                     credits, flush_done, err_overflow);
        else npass++;
        do_reset();
    endtask

    task automatic test_credit_exhaust();
        do_reset();
        for (int i = 0; i < 8; i++) step(2'b01, 1'b1, 1'b0, 1'b0);
        ntot++;
        if (credits !== 4'd0) $display("FAIL exhaust_credits: got %0d want 0", credits);
        else npass++;
        step(2'b01, 1'b1, 1'b0, 1'b0);
        ntot++;
        if (obs_rdy !== 2'b00) $display("FAIL exhaust_stall: got %b want 00", obs_rdy);
        else npass++;
        step(2'b01, 1'b1, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        ntot++;
        if (obs_rdy !== 2'b01) $display("FAIL token_grant: got %b want 01", obs_rdy);
        else npass++;
        step(2'b01, 1'b1, 1'b0, 1'b0);
        ntot++;
        if (obs_rdy !== 2'b00) $display("FAIL token_single: got %b want 00", obs_rdy);
        else npass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(2'b11, 1'b1, 1'b1, 1'b0);
            ntot++;
            if (obs_rdy !== ((k % 2 == 0) ? 2'b01 : 2'b10))
                $display("FAIL rr_order[%0d]: got %b want %b", k, obs_rdy,
                         (k % 2 == 0) ? 2'b01 : 2'b10);
            else npass++;
        end
        step(2'b00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        logic [63:0] hold;
        do_reset();
        step(2'b01, 1'b1, 1'b0, 1'b0);
        hold = sbq[0].data;
        for (int k = 0; k < 3; k++) begin
            step(2'b11, 1'b0, 1'b0, 1'b0);
            ntot++;
            if (obs_rdy !== 2'b00 || link_data !== hold || credits !== 4'd7)
                $display("FAIL stall[%0d]: got rdy=%b d=%h cred=%0d want 00/%h/7",
                         k, obs_rdy, link_data, credits, hold);
            else npass++;
        end
        step(2'b11, 1'b1, 1'b0, 1'b0);
        ntot++;
        if (obs_rdy !== 2'b10) $display("FAIL stall_resume: got %b want 10", obs_rdy);
        else npass++;
        step(2'b00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_net_zero();
        do_reset();
        for (int i = 0; i < 3; i++) step(2'b01, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b1, 1'b0);
        ntot++;
        if (obs_rdy !== 2'b01 || credits !== 4'd5)
            $display("FAIL net_zero: got rdy=%b cred=%0d want 01/5", obs_rdy, credits);
        else npass++;
        step(2'b00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        do_reset();
        step(2'b00, 1'b1, 1'b1, 1'b0);
        ntot++;
        if (err_overflow !== 1'b1 || credits !== 4'd8)
            $display("FAIL overflow: got err=%b cred=%0d want 1/8", err_overflow, credits);
        else npass++;
        step(2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b0);
        ntot++;
        if (err_overflow !== 1'b1) $display("FAIL overflow_sticky: got %b want 1", err_overflow);
        else npass++;
        rst = 1'b0;
        #1;
        ntot++;
        if (err_overflow !== 1'b0 || link_valid !== 1'b0)
            $display("FAIL overflow_clear: got err=%b v=%b want 0/0", err_overflow, link_valid);
        else npass++;
        do_reset();
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) step(2'b01, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 1'b0, 1'b1);
        ntot++;
        if (obs_rdy !== 2'b00) $display("FAIL flush_first: got %b want 00", obs_rdy);
        else npass++;
        for (int k = 0; k < 3; k++) begin
            step(2'b01, 1'b1, 1'b1, 1'b1);
            ntot++;
            if (obs_rdy !== 2'b00) $display("FAIL flush_noissue[%0d]: got %b want 00", k, obs_rdy);
            else npass++;
        end
        ntot++;
        if (credits !== 4'd8 || flush_done !== 1'b0)
            $display("FAIL flush_credits: got cred=%0d done=%b want 8/0", credits, flush_done);
        else npass++;
        step(2'b01, 1'b1, 1'b0, 1'b1);
        ntot++;
        if (flush_done !== 1'b1) $display("FAIL flush_done: got %b want 1", flush_done);
        else npass++;
        step(2'b01, 1'b1, 1'b0, 1'b0);
        ntot++;
        if (obs_rdy !== 2'b00) $display("FAIL done_noissue: got %b want 00", obs_rdy);
        else npass++;
        step(2'b01, 1'b1, 1'b0, 1'b0);
        ntot++;
        if (obs_rdy !== 2'b01) $display("FAIL flush_resume: got %b want 01", obs_rdy);
        else npass++;
        step(2'b00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_credit_exhaust();
        test_round_robin();
        test_stall();
        test_net_zero();
        test_overflow();
        test_flush();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
